// File: rtl/uart_arb_pkg.sv
// Shared types and bounds for the UART port arbiter: FSM states, operation
// kinds and the parameter limits the arbiter supports.
package uart_arb_pkg;

  localparam int MAX_REQ        = 8;
  localparam int MAX_RD_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  // Keeps the read-latency counter inside its supported range.
  function automatic int clamp_latency(input int lat);
    if (lat > MAX_RD_LATENCY) return MAX_RD_LATENCY;
    if (lat < 1) return 1;
    return lat;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from pointer+1 (wrapping) for the first
// eligible requester and moves the pointer to the winner on every accepted grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx_sel;
  int            idx;

  always_comb begin
    grant   = '0;
    valid   = 1'b0;
    win_idx = ptr_reg;
    idx     = 0;
    idx_sel = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_sel = PW'(idx);
      if (!valid && eligible[idx_sel]) begin
        grant[idx_sel] = 1'b1;
        valid          = 1'b1;
        win_idx        = idx_sel;
      end
    end
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ptr_reg <= PW'(NUM_REQ - 1);
    end else if (update && valid) begin
      ptr_reg <= win_idx;
    end
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one UART byte interface between NUM_REQ requesters: one operation in
// flight, round-robin grants, read beats write within a requester.
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_BITS  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]           req_rd,
  output logic [NUM_REQ-1:0]           wr_ack,
  output logic [NUM_REQ-1:0]           rd_ack,
  output logic [DATA_BITS-1:0]         rd_data,
  output logic                         busy,
  output logic                         rd_uart_en,
  output logic                         wr_uart_en,
  output logic [DATA_BITS-1:0]         TX_data,
  input  logic [DATA_BITS-1:0]         RX_data,
  input  logic                         Empty,
  input  logic                         Full
);

  localparam int LAT = clamp_latency(RD_LATENCY);
  localparam int CW  = $clog2(LAT + 1);

  arb_state_t           state_reg;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic [CW-1:0]        cnt_reg;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_valid;
  logic                 arb_update;
  logic [DATA_BITS-1:0] wdata_sel;
  arb_op_t              op_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = (req_rd[gi] && !Empty) || (req_wr[gi] && !Full);
    end
  endgenerate

  assign arb_update = (state_reg == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .eligible      (eligible),
    .update        (arb_update),
    .grant         (arb_grant),
    .valid         (arb_valid)
  );

  // A granted requester gets a read whenever its read is itself eligible.
  always_comb begin
    op_sel    = ((|(arb_grant & req_rd)) && !Empty) ? OP_RD : OP_WR;
    wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) wdata_sel = wdata_sel | req_wdata[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      rd_uart_en <= 1'b0;
      wr_uart_en <= 1'b0;
      TX_data    <= '0;
      rd_data    <= '0;
      wr_ack     <= '0;
      rd_ack     <= '0;
    end else begin
      rd_uart_en <= 1'b0;
      wr_uart_en <= 1'b0;
      wr_ack     <= '0;
      rd_ack     <= '0;
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            gnt_reg <= arb_grant;
            busy    <= 1'b1;
            if (op_sel == OP_RD) begin
              state_reg  <= RD_WAIT;
              rd_uart_en <= 1'b1;
              cnt_reg    <= CW'(LAT);
            end else begin
              state_reg  <= WR;
              wr_uart_en <= 1'b1;
              wr_ack     <= arb_grant;
              TX_data    <= wdata_sel;
            end
          end
        end
        // Returning to IDLE after every push forces Full to be re-sampled.
        WR: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        RD_WAIT: begin
          if (cnt_reg == CW'(1)) begin
            rd_data   <= RX_data;
            rd_ack    <= gnt_reg;
            state_reg <= RD_DONE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RD_DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
